fclass_vec_gen: RTL
===================

// Module: fclass_vec_gen
// PURPOSE
//  Inverse of the FP32 classifier: accepts a one-hot class request and emits a burst of IEEE-754
//  single-precision values that all belong to that class. Pseudo-random fields come from an LFSR.
//  Drives the floating ALU test/stimulus path and feeds operands to the class unit. Valid/ready on both sides.
// PARAMETERS
//  SEED   32'hACE12D45  LFSR reset value; 0 is illegal and is replaced by 32'h1
//  CNT_W  8             width of the burst-length field
// PORTS
//  CLK        in   1      clock, rising edge
//  RST        in   1      asynchronous, active-high reset
//  EN         in   1      global enable; low = all state frozen
//  req_valid  in   1      request valid
//  req_ready  out  1      request accepted when req_valid & req_ready
//  req_class  in   10     one-hot class select:
//                         b0 -inf, b1 -norm, b2 -subn, b3 -0, b4 +0,
//                         b5 +subn, b6 +norm, b7 +inf, b8 sNaN, b9 qNaN
//  req_count  in   CNT_W  number of values to emit
//  out_valid  out  1      out_f valid
//  out_ready  in   1      consumer ready
//  out_f      out  32     generated value
//  out_class  out  10     latched req_class, echoed with out_f
//  out_last   out  1      marks the final value of the burst
//  done       out  1      1-cycle pulse when the burst completes (also when count==0)
//  err        out  1      1-cycle pulse when a request is rejected (req_class not exactly one-hot)
//  busy       out  1      high while in state GEN
// BEHAVIOUR
//  Reset: all outputs are 0, except req_ready, which follows its formula (1 while EN=1).
//         State=IDLE; LFSR=SEED; remaining count=0.
//  LFSR: 32-bit Galois, mask 32'h80200003.
//   - Advances exactly one step per output handshake (out_valid & out_ready).
//   - Holds between bursts; it is not reseeded per request.
//  EN=0: FSM, LFSR, out_f and counters hold. req_ready=0, out_valid=0, done=0, err=0.
//        On re-enable the same out_f is re-presented.
//  FSM states: IDLE, GEN.
//   IDLE: req_ready=EN. On request accept:
//    - req_class not one-hot (zero bits or several bits): err=1 next cycle; stay in IDLE.
//    - req_count==0: done=1 next cycle; stay in IDLE.
//    - otherwise: latch class and count, load out_f from the current LFSR state; -> GEN.
//      out_valid=1 in the next cycle (latency 1).
//   GEN: req_ready=0; out_valid=EN.
//    - out_f, out_class and out_last are stable while out_valid & ~out_ready.
//    - Handshake with remaining>1: decrement, step the LFSR, load the next out_f. No bubble.
//    - out_last=1 when remaining==1.
//    - Handshake while out_last=1: out_valid=0 and done=1 next cycle; -> IDLE.
//      req_ready may be 1 in the same cycle as done.
//  Value construction from LFSR word r (s = sign taken from the class; NaN sign = r[31]):
//    +/-inf   {s, 8'hFF, 23'h0}
//    +/-0     {s, 31'h0}
//    +/-subn  {s, 8'h00, m};          m = r[22:0], forced to 23'h1 if zero
//    +/-norm  {s, e, r[22:0]};        e = r[30:23]; e=00 -> 01, e=FF -> FE
//    sNaN     {r[31], 8'hFF, 1'b0, p}; p = r[21:0], forced to 22'h1 if zero
//    qNaN     {r[31], 8'hFF, 1'b1, r[21:0]}
//  Corner cases:
//   - A request presented while in GEN is not accepted.
//   - RST mid-burst: outputs clear immediately; the burst is abandoned; no done pulse.
//   - Count maximum (2^CNT_W-1) is supported; the counter does not wrap.
// TESTING
//  1. req_class=10'h080, req_count=3, out_ready=1:
//     -> 3 consecutive cycles of out_f=32'h7F800000; out_last on the 3rd; done the next cycle.
//  2. req_class=10'h008, req_count=1 -> out_f=32'h80000000, out_last=1, then done.
//     Then 10'h010 -> 32'h00000000.
//  3. req_class=10'h003 -> err pulse; out_valid stays 0; LFSR unchanged.
//     Then req_count=0 with a valid class -> done pulse only.
//  4. Each class bit, req_count=255, random out_ready:
//     - bench classifier of every out_f equals req_class;
//     - no normal value with exponent 00/FF; no zero mantissa on subn/sNaN;
//     - out_f stable while stalled.
//  5. Toggle EN=0 for 5 cycles mid-burst with out_ready=1:
//     - out_valid=0 while EN=0; the same out_f resumes afterwards;
//     - total handshakes equal req_count.
//  6. Assert RST during the 2nd value of a 10-value burst:
//     - out_valid=0 immediately; LFSR back to SEED;
//     - the next 10'h040 burst reproduces the post-reset sequence exactly.

Source files
------------

// File: rtl/fclass_vec_gen.sv
// fclass_vec_gen: emits bursts of FP32 values that all fall in one requested IEEE-754 class
//   i_clk, i_rst (async, active high), i_en (global enable; low freezes all state)
//   i_req_valid/o_req_ready, i_req_class (one-hot, 10 bits), i_req_count (burst length)
//   o_out_valid/i_out_ready, o_out_f, o_out_class, o_out_last
//   o_done (burst complete or zero-length), o_err (rejected class), o_busy (in GEN)
module fclass_vec_gen #(
    parameter logic [31:0] SEED  = 32'hACE12D45,
    parameter int          CNT_W = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_en,
    input  logic             i_req_valid,
    output logic             o_req_ready,
    input  logic [9:0]       i_req_class,
    input  logic [CNT_W-1:0] i_req_count,
    output logic             o_out_valid,
    input  logic             i_out_ready,
    output logic [31:0]      o_out_f,
    output logic [9:0]       o_out_class,
    output logic             o_out_last,
    output logic             o_done,
    output logic             o_err,
    output logic             o_busy
);
    localparam logic [31:0] LFSR_MASK = 32'h80200003;
    localparam logic [31:0] SEED_OK   = (SEED == 32'h0) ? 32'h1 : SEED;

    typedef enum logic {IDLE, GEN} state_t;

    state_t           r_state, w_next;
    logic [31:0]      r_lfsr, r_f, w_lfsr_step;
    logic [CNT_W-1:0] r_rem;
    logic [9:0]       r_class;
    logic             r_done, r_err;
    logic             w_acc, w_hs, w_onehot, w_last, w_start, w_zero;

    // Shape a random word into the class: sign from the class, exponent/mantissa
    // clamped so the value cannot drift into a neighbouring class.
    function automatic logic [31:0] build(input logic [31:0] r, input logic [9:0] c);
        logic        s;
        logic [7:0]  e;
        logic [22:0] m;
        logic [21:0] p;
        s = |c[3:0];
        e = (r[30:23] == 8'h00) ? 8'h01 : (r[30:23] == 8'hFF) ? 8'hFE : r[30:23];
        m = (r[22:0] == 23'h0) ? 23'h1 : r[22:0];
        p = (r[21:0] == 22'h0) ? 22'h1 : r[21:0];
        return (c[0] | c[7]) ? {s, 8'hFF, 23'h0} :
               (c[3] | c[4]) ? {s, 31'h0} :
               (c[2] | c[5]) ? {s, 8'h00, m} :
               (c[1] | c[6]) ? {s, e, r[22:0]} :
               c[8]          ? {r[31], 8'hFF, 1'b0, p} :
                               {r[31], 8'hFF, 1'b1, r[21:0]};
    endfunction

    assign w_onehot    = (i_req_class != 10'h0) && ((i_req_class & (i_req_class - 10'd1)) == 10'h0);
    assign w_acc       = i_req_valid & o_req_ready;
    assign w_zero      = (i_req_count == '0);
    assign w_start     = w_acc & w_onehot & ~w_zero;
    assign w_hs        = o_out_valid & i_out_ready;
    assign w_last      = (r_state == GEN) && (r_rem == CNT_W'(1));
    assign w_lfsr_step = r_lfsr[0] ? ((r_lfsr >> 1) ^ LFSR_MASK) : (r_lfsr >> 1);
    assign o_out_f     = r_f;
    assign o_out_class = r_class;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) r_state <= IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        if (r_state == IDLE && w_start) w_next = GEN;
        if (r_state == GEN && w_hs && w_last) w_next = IDLE;
    end

    always_comb begin
        o_req_ready = i_en & (r_state == IDLE);
        o_out_valid = i_en & (r_state == GEN);
        o_busy      = (r_state == GEN);
        o_out_last  = w_last;
        o_done      = r_done & i_en;
        o_err       = r_err & i_en;
    end

    // Every handshake, including the last, steps the LFSR so the next burst
    // continues the sequence rather than repeating the final word.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_lfsr  <= SEED_OK;
            r_f     <= 32'h0;
            r_rem   <= '0;
            r_class <= 10'h0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_done <= (w_hs & w_last) | (w_acc & w_onehot & w_zero);
            r_err  <= w_acc & ~w_onehot;
            if (w_start) begin
                r_class <= i_req_class;
                r_rem   <= i_req_count;
                r_f     <= build(r_lfsr, i_req_class);
            end else if (w_hs) begin
                r_lfsr <= w_lfsr_step;
                r_rem  <= r_rem - CNT_W'(1);
                if (!w_last) r_f <= build(w_lfsr_step, r_class);
            end
        end
    end
endmodule
